mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU datapath's memory interface. Accepts read and write requests driven from the MAR/MDR side, holds a synchronous word-addressed RAM, and returns read data on the bus that feeds MDR's memory input (MDataIN). Completion is signalled with a one-cycle `mem_ready` pulse, so the control unit can stall until memory finishes.

## Interface
- `ADDR_WIDTH`, 9: number of address bits used. Depth is 2^ADDR_WIDTH words.
- `READ_LATENCY`, 2: number of edges from request acceptance to read completion. Legal range is 1 to 15.
- `clk`  input  1: system clock. All state changes on the rising edge.
- `clr`  input  1: reset, synchronous and active-high, sampled on the `clk` rising edge.
- `mar_addr`  input  32: word address taken from MAR.
- `read_req`  input  1: read request, level-sampled.
- `write_req`  input  1: write request, level-sampled.
- `mdr_wdata`  input  32: write data taken from MDR.
- `mdata_in`  output  32: read data presented to MDR's memory input.
- `mem_ready`  output  1: one-cycle completion pulse.
- `busy`  output  1: high while a request is in flight.
- `error`  output  1: one-cycle pulse when a request is rejected.

## Operation
- FSM states:
  - IDLE: the only state that samples requests.
  - READ_WAIT: holds a latency counter of 4 bits.
  - WRITE: commits the write.
- Request sampling in IDLE, on each edge:
  - `read_req` alone with address in range: latch the address, load counter = 1, go to READ_WAIT.
  - `write_req` alone with address in range: latch the address and data, go to WRITE.
  - `read_req` and `write_req` both high: reject. Pulse `error`, perform nothing, stay in IDLE.
  - Address out of range (any of `mar_addr[31:ADDR_WIDTH]` nonzero): reject. Pulse `error`, leave RAM and `mdata_in` unchanged, stay in IDLE.
- READ_WAIT:
  - While counter < READ_LATENCY: increment the counter.
  - When counter == READ_LATENCY: load `mdata_in` with RAM[latched addr], pulse `mem_ready`, go to IDLE.
- WRITE: write RAM[latched addr] = latched data, pulse `mem_ready`, go to IDLE.
- Requests asserted outside IDLE are ignored, not queued. Inputs that change after acceptance have no effect because address and data are latched.
- `mdata_in` holds the last completed read value until the next read completes. Writes never change it.
- A read from an address written earlier returns the new data. There is no write-to-read forwarding hazard because operations never overlap.

## Timing
- Reset values, applied at the first edge with `clr`=1: state IDLE, counter 0, `mdata_in`=0, `mem_ready`=0, `busy`=0, `error`=0.
- RAM contents are not cleared by reset.
- Reset mid-operation aborts the request. An in-flight read never pulses `mem_ready`. A write still in the WRITE state at the reset edge is not committed.
- `clr` has priority over all requests on the same edge.
- Let E0 be the acceptance edge.
- Read:
  - `busy`=1 after E0 through E(L-1), where L = READ_LATENCY.
  - At E(L): `busy`=0, `mem_ready`=1, and `mdata_in` is valid.
  - At E(L+1): `mem_ready`=0.
- Write:
  - `busy`=1 after E0.
  - At E1: RAM is updated, `busy`=0, `mem_ready`=1.
- Earliest next acceptance is one edge after completion: E(L+1) for a read, E2 for a write.
- `error` goes high after the rejecting edge for exactly one cycle. `busy` stays 0 during a rejection.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `clr` for 2 cycles while `read_req`=1 -> all outputs are 0 and no `mem_ready` pulse occurs.
- Write then read, L=2:
  - Write 0xDEADBEEF to address 0x005 -> `mem_ready` at E1.
  - Read address 0x005 -> `busy` high for 2 cycles, then `mem_ready` with `mdata_in`=0xDEADBEEF at E2.
  - `mdata_in` holds that value afterwards.
- Back-to-back:
  - Write 0x1 to address 0x000 and 0x2 to address 0x1FF, then hold `read_req` continuously while alternating the address.
  - Reads complete every 3 cycles, returning 0x1 and 0x2.
  - Requests held during `busy` are ignored.
- Rejects:
  - `read_req` and `write_req` both high at address 0x010 -> `error` pulse, RAM[0x010] unchanged.
  - Read of address 0x00000200 -> `error` pulse, `mdata_in` unchanged, `busy` never asserted.
- Reset mid-operation:
  - Accept a read, then assert `clr` at E1 -> no `mem_ready`, `mdata_in`=0.
  - Accept a write of 0xAAAA5555 with `clr` at E1 -> a later read returns the old value.
- Latency parameter: with READ_LATENCY=1 and READ_LATENCY=15 -> `mem_ready` arrives exactly at E1 and E15 respectively.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed synchronous RAM responder for the MAR/MDR memory port.
// Latency: READ_LATENCY edges after acceptance for reads, one edge for writes.
// Backpressure: requests are only sampled in IDLE; requests seen while busy are dropped.
module mem_responder #(
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] mar_addr,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [31:0] mdr_wdata,
  output logic [31:0] mdata_in,
  output logic        mem_ready,
  output logic        busy,
  output logic        error
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT   = 4'(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ_WAIT,
    S_WRITE
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             ram [DEPTH];
  logic                    addr_oob;

  // Any set bit above the implemented address range makes the request illegal.
  assign addr_oob = |mar_addr[31:ADDR_WIDTH];

  // Control FSM: sample requests in IDLE, time reads, drive registered status pulses.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      mdata_in  <= 32'd0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      error     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (read_req || write_req) begin
            if ((read_req && write_req) || addr_oob) begin
              error <= 1'b1;
            end else begin
              addr_q <= mar_addr[ADDR_WIDTH-1:0];
              busy   <= 1'b1;
              if (read_req) begin
                cnt   <= 4'd1;
                state <= S_READ_WAIT;
              end else begin
                wdata_q <= mdr_wdata;
                state   <= S_WRITE;
              end
            end
          end
        end
        S_READ_WAIT: begin
          if (cnt == LAT) begin
            mdata_in  <= ram[addr_q];
            mem_ready <= 1'b1;
            busy      <= 1'b0;
            cnt       <= 4'd0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WRITE: begin
          mem_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM commit; a reset on the commit edge aborts the write, contents are never cleared.
  always_ff @(posedge clk) begin
    if (!clr && state == S_WRITE) begin
      ram[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] mar_addr;
  logic        read_req;
  logic        write_req;
  logic [31:0] mdr_wdata;

  logic [31:0] mdata_in, mdata1, mdata15;
  logic        mem_ready, rdy1, rdy15;
  logic        busy, busy1, busy15;
  logic        error, err1, err15;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: sparse memory image plus the last value a read returned.
  logic [31:0] model [int];
  int          wr_q[$];
  logic [31:0] last_rd;
  int          last_done;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(9), .READ_LATENCY(2)) dut (
    .clk(clk), .clr(clr), .mar_addr(mar_addr), .read_req(read_req),
    .write_req(write_req), .mdr_wdata(mdr_wdata), .mdata_in(mdata_in),
    .mem_ready(mem_ready), .busy(busy), .error(error));

  mem_responder #(.ADDR_WIDTH(9), .READ_LATENCY(1)) dut1 (
    .clk(clk), .clr(clr), .mar_addr(mar_addr), .read_req(read_req),
    .write_req(write_req), .mdr_wdata(mdr_wdata), .mdata_in(mdata1),
    .mem_ready(rdy1), .busy(busy1), .error(err1));

  mem_responder #(.ADDR_WIDTH(9), .READ_LATENCY(15)) dut15 (
    .clk(clk), .clr(clr), .mar_addr(mar_addr), .read_req(read_req),
    .write_req(write_req), .mdr_wdata(mdr_wdata), .mdata_in(mdata15),
    .mem_ready(rdy15), .busy(busy15), .error(err15));

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    mar_addr  = a;
    mdr_wdata = d;
    write_req = 1'b1;
    tick();                               // E0
    write_req = 1'b0;
    chk_b("wr_busy_e0", busy, 1'b1);
    chk_b("wr_rdy_e0", mem_ready, 1'b0);
    tick();                               // E1
    chk_b("wr_rdy_e1", mem_ready, 1'b1);
    chk_b("wr_busy_e1", busy, 1'b0);
    chk_w("wr_keeps_mdata", mdata_in, last_rd);
    model[int'(a)] = d;
    wr_q.push_back(int'(a));
  endtask

  // Reads complete exactly 2 edges after acceptance; optional hold keeps read_req high
  // with a different address to show requests during busy are dropped.
  task automatic do_read(input logic [31:0] a, input bit hold, input logic [31:0] alt);
    int n;
    bit done;
    logic [31:0] exp;
    mar_addr = a;
    read_req = 1'b1;
    tick();                               // E0
    chk_b("rd_busy_e0", busy, 1'b1);
    if (hold) mar_addr = alt;
    else      read_req = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (mem_ready) done = 1'b1;
      else chk_b("rd_busy_wait", busy, 1'b1);
    end
    exp = model.exists(int'(a)) ? model[int'(a)] : 32'hx;
    chk_w("rd_latency", 32'(n), 32'd2);
    chk_b("rd_busy_done", busy, 1'b0);
    chk_w("rd_data", mdata_in, exp);
    last_rd   = exp;
    last_done = cyc;
  endtask

  task automatic do_reject(input logic [31:0] a, input bit both);
    bit wr;
    wr = both ? 1'b1 : 1'($urandom_range(0, 1));
    mar_addr  = a;
    mdr_wdata = $urandom;
    write_req = wr;
    read_req  = both ? 1'b1 : !wr;
    tick();
    read_req  = 1'b0;
    write_req = 1'b0;
    chk_b("rej_error", error, 1'b1);
    chk_b("rej_busy", busy, 1'b0);
    chk_b("rej_rdy", mem_ready, 1'b0);
    chk_w("rej_mdata", mdata_in, last_rd);
    tick();
    chk_b("rej_error_clr", error, 1'b0);
    chk_b("rej_busy_after", busy, 1'b0);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    last_rd = 32'd0;
  endtask

  initial begin
    int prev_done;
    int t1, t15;
    clr = 1'b1; read_req = 1'b1; write_req = 1'b0;
    mar_addr = 32'h5; mdr_wdata = 32'd0;
    last_rd = 32'd0; last_done = 0;

    // Reset held two cycles with a read pending: everything stays zero.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_w("rst_mdata", mdata_in, 32'd0);
      chk_b("rst_rdy", mem_ready, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_error", error, 1'b0);
    end
    clr = 1'b0; read_req = 1'b0;
    tick();
    chk_b("post_rst_rdy", mem_ready, 1'b0);

    // Write then read at 0x005.
    do_write(32'h005, 32'hDEADBEEF);
    do_read(32'h005, 1'b0, 32'h0);
    tick(); tick();
    chk_w("mdata_hold", mdata_in, 32'hDEADBEEF);

    // Back-to-back reads with read_req held continuously.
    do_write(32'h000, 32'h1);
    do_write(32'h1FF, 32'h2);
    do_read(32'h000, 1'b1, 32'h1FF);
    prev_done = last_done;
    do_read(32'h1FF, 1'b1, 32'h000);
    chk_w("b2b_spacing", 32'(last_done - prev_done), 32'd3);
    prev_done = last_done;
    do_read(32'h000, 1'b1, 32'h1FF);
    chk_w("b2b_spacing2", 32'(last_done - prev_done), 32'd3);
    read_req = 1'b0;
    tick();

    // Rejections: both requests, then out-of-range address.
    do_write(32'h010, 32'h0BADF00D);
    do_reject(32'h010, 1'b1);
    do_read(32'h010, 1'b0, 32'h0);
    mar_addr = 32'h200; read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk_b("oob_error", error, 1'b1);
    chk_b("oob_busy", busy, 1'b0);
    chk_w("oob_mdata", mdata_in, last_rd);
    tick();
    chk_b("oob_error_clr", error, 1'b0);
    chk_b("oob_busy2", busy, 1'b0);

    // Reset during a read: no completion, mdata cleared.
    mar_addr = 32'h005; read_req = 1'b1;
    tick();
    read_req = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    last_rd = 32'd0;
    chk_b("rstrd_rdy", mem_ready, 1'b0);
    chk_w("rstrd_mdata", mdata_in, 32'd0);
    chk_b("rstrd_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_b("rstrd_no_rdy", mem_ready, 1'b0);
    end

    // Reset during a write: the old value survives.
    mar_addr = 32'h005; mdr_wdata = 32'hAAAA5555; write_req = 1'b1;
    tick();
    write_req = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    last_rd = 32'd0;
    chk_b("rstwr_rdy", mem_ready, 1'b0);
    tick();
    do_read(32'h005, 1'b0, 32'h0);

    // Randomized traffic against the memory image.
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 5);
      if (k <= 1) begin
        do_write(32'($urandom_range(0, 511)), $urandom);
      end else if (k <= 3 && wr_q.size() > 0) begin
        do_read(32'(wr_q[$urandom_range(0, wr_q.size() - 1)]), 1'b0, 32'h0);
      end else if (k == 4) begin
        do_reject(32'($urandom_range(0, 511)), 1'b1);
      end else begin
        do_reject((32'($urandom_range(1, 32'h7FFFFF)) << 9) | 32'($urandom_range(0, 511)), 1'b0);
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        chk_b("idle_rdy", mem_ready, 1'b0);
        chk_b("idle_busy", busy, 1'b0);
      end
    end

    // Latency extremes on the L=1 and L=15 instances.
    do_reset();
    do_write(32'h007, 32'h13579BDF);
    mar_addr = 32'h007; read_req = 1'b1;
    tick();
    read_req = 1'b0;
    t1 = 0; t15 = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (rdy1 && t1 == 0)  t1  = n;
      if (rdy15 && t15 == 0) t15 = n;
    end
    chk_w("lat1_edge", 32'(t1), 32'd1);
    chk_w("lat15_edge", 32'(t15), 32'd15);
    chk_w("lat1_data", mdata1, 32'h13579BDF);
    chk_w("lat15_data", mdata15, 32'h13579BDF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
